// File: rtl/uart_tx.sv
// uart_tx: byte-stream UART transmitter, 8N1 or 8E1 framing, LSB first.
// Ports: clk_i, rst_i (sync, active-high), valid_i/data_i/ready_o byte
// stream in, tx_o serial line (idle high), busy_o frame in progress.
// Define UART_TX_PARITY_EN to add an even parity bit after the data bits.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cfg
    $error("uart_tx: CLKS_PER_BIT must be 2..65535");
  end

  localparam int CW =
    (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      idx, idx_n;
  logic [7:0]      sh, sh_n;
  logic            tx, tx_n;
  logic            last;
  logic            accept;
`ifdef UART_TX_PARITY_EN
  logic            par, par_n;
`endif

  assign last    = (cnt == LAST);
  assign ready_o = !rst_i &&
    (state == IDLE || (state == STOP && last));
  assign accept  = valid_i & ready_o;
  assign tx_o    = tx;
  assign busy_o  = (state != IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
`ifdef UART_TX_PARITY_EN
    par_n   = par;
`endif
    if (state != IDLE)
      cnt_n = last ? '0 : cnt + CW'(1);
    unique case (state)
      IDLE: ;
      START:
        if (last) state_n = DATA;
      DATA:
        if (last) begin
          sh_n = {1'b0, sh[7:1]};
`ifdef UART_TX_PARITY_EN
          par_n = par ^ sh[0];
`endif
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + 3'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
      PARITY:
        if (last) state_n = STOP;
`endif
      STOP:
        if (last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Accept wins over the STOP exit so frames run back-to-back.
    if (accept) begin
      state_n = START;
      sh_n    = data_i;
      cnt_n   = '0;
      idx_n   = '0;
`ifdef UART_TX_PARITY_EN
      par_n   = 1'b0;
`endif
    end
    // Line level follows the next state so tx stays aligned with it.
    tx_n = 1'b1;
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = sh_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_n = par_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
      tx    <= tx_n;
`ifdef UART_TX_PARITY_EN
      par   <= par_n;
`endif
    end
  end

endmodule
